instr_mem_ld: RTL and testbench

INSTR_MEM_LD -- requirements
Module: instr_mem_ld

---
 rtl/cpu_pkg.sv | 13 +
 rtl/instr_ram.sv | 40 ++++
 rtl/instr_mem_ld.sv | 134 +++++++++++++
 tb/tb_instr_mem_ld.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction memory loader: FSM states and the NOP word.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Word returned for fetches beyond the populated memory; sliced to DATA_W by users.
    localparam logic [63:0] NOP_WORD = 64'd0;

endpackage

// File: rtl/instr_ram.sv
// Instruction storage: one write port, one synchronous read port, registered read data.
// Array is deliberately unreset; only the read register returns to zero on reset.
module instr_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // Callers guarantee addresses < DEPTH, so only the low index bits matter.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr[IDX_W-1:0]];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_ld.sv
// Instruction memory with a program-load port and a 1-cycle-latency fetch port.
// Fetch result is frozen while stall is high; fetch_ready drops with stall or outside RUN.
module instr_mem_ld
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_wr_en,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              load_ovf,
    input  logic [ADDR_W-1:0] PCAdd_pc,
    input  logic              fetch_req,
    input  logic              stall,
    output logic              fetch_ready,
    output logic [DATA_W-1:0] M_instruction,
    output logic              fetch_valid,
    output logic              fetch_fault
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_ptr;
    logic              r_ovf;
    logic              r_valid;
    logic              r_fault;
    logic              r_nop;
    logic              w_full;
    logic              w_load_wr;
    logic              w_ram_we;
    logic              w_pc_ok;
    logic              w_accept;
    logic              w_leave_run;
    logic              w_issue;
    logic [DATA_W-1:0] w_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // load_start outranks load_done, so a simultaneous pair lands in LOAD.
    always_comb begin
        w_state_nxt = r_state;
        fetch_ready = 1'b0;
        if (load_start) begin
            w_state_nxt = ST_LOAD;
        end else if (load_done) begin
            w_state_nxt = ST_RUN;
        end
        if (r_state == ST_RUN) begin
            fetch_ready = !stall;
        end
    end

    assign w_full      = (r_ptr == DEPTH_C);
    assign w_load_wr   = (r_state == ST_LOAD) && load_wr_en && !load_start;
    assign w_ram_we    = w_load_wr && !w_full;
    assign w_pc_ok     = ({1'b0, PCAdd_pc} < DEPTH_C);
    assign w_accept    = fetch_req && fetch_ready;
    assign w_leave_run = (r_state == ST_RUN) && (w_state_nxt != ST_RUN);
    assign w_issue     = w_accept && !w_leave_run;

    // Pointer doubles as load_count: both advance only on successful writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_ovf <= 1'b0;
        end else if (load_start) begin
            r_ptr <= '0;
            r_ovf <= 1'b0;
        end else if (w_load_wr) begin
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_ptr <= r_ptr + (ADDR_W+1)'(1);
            end
        end
    end

    // r_nop latches an out-of-range fetch so the NOP word survives later idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_nop   <= 1'b0;
        end else if (w_leave_run) begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else if (stall) begin
            r_valid <= r_valid;
        end else if (w_issue) begin
            r_valid <= 1'b1;
            r_fault <= !w_pc_ok;
            r_nop   <= !w_pc_ok;
        end else begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end
    end

    instr_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_ram_we),
        .i_waddr (r_ptr[ADDR_W-1:0]),
        .i_wdata (load_data),
        .i_re    (w_issue && w_pc_ok),
        .i_raddr (PCAdd_pc),
        .o_rdata (w_rdata)
    );

    assign M_instruction = r_nop ? NOP_WORD[DATA_W-1:0] : w_rdata;
    assign fetch_valid   = r_valid;
    assign fetch_fault   = r_fault;
    assign load_count    = r_ptr;
    assign load_ovf      = r_ovf;

endmodule

// File: tb/tb_instr_mem_ld.sv
// Bench for instr_mem_ld (DEPTH=16, ADDR_W=5) against a word-array reference of the program memory.
module tb_instr_mem_ld;

    localparam int DW  = 16;
    localparam int AW  = 5;
    localparam int DEP = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load_start = 1'b0;
    logic          load_wr_en = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_done = 1'b0;
    logic [AW-1:0] pc = '0;
    logic          fetch_req = 1'b0;
    logic          stall = 1'b0;
    wire  [AW:0]   load_count;
    wire           load_ovf;
    wire           fetch_ready;
    wire  [DW-1:0] m_instr;
    wire           fetch_valid;
    wire           fetch_fault;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] ref_mem [DEP];
    bit            ref_known [DEP];

    instr_mem_ld #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_start    (load_start),
        .load_wr_en    (load_wr_en),
        .load_data     (load_data),
        .load_done     (load_done),
        .load_count    (load_count),
        .load_ovf      (load_ovf),
        .PCAdd_pc      (pc),
        .fetch_req     (fetch_req),
        .stall         (stall),
        .fetch_ready   (fetch_ready),
        .M_instruction (m_instr),
        .fetch_valid   (fetch_valid),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [DW-1:0] words[$]);
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        for (int i = 0; i < words.size(); i++) begin
            load_wr_en = 1'b1;
            load_data  = words[i];
            if (i < DEP) begin
                ref_mem[i]   = words[i];
                ref_known[i] = 1'b1;
            end
            cyc();
        end
        load_wr_en = 1'b0;
        load_done  = 1'b1;
        cyc();
        load_done  = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (load_count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", load_count); end
        n_cmp++; if (load_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", load_ovf); end
        n_cmp++; if (m_instr !== '0) begin n_err++; $display("FAIL reset_instr got %h want 0000", m_instr); end
        n_cmp++; if ({fetch_valid, fetch_fault} !== 2'b00) begin n_err++; $display("FAIL reset_vf got %b%b want 00", fetch_valid, fetch_fault); end
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready cycle %0d got %b want 0", i, fetch_ready); end
        end
    endtask

    task automatic test_basic_fetch();
        logic [DW-1:0] w[$];
        w = '{16'h1438, 16'h282F, 16'h1121, 16'h1242};
        do_load(w);
        n_cmp++; if (load_count !== 6'd4) begin n_err++; $display("FAIL basic_count got %0d want 4", load_count); end
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1'b1;
            pc = AW'(i);
            #1;
            n_cmp++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready addr %0d got %b want 1", i, fetch_ready); end
            cyc();
            n_cmp++; if (m_instr !== w[i] || fetch_valid !== 1'b1 || fetch_fault !== 1'b0)
                begin n_err++; $display("FAIL basic_fetch addr %0d got %h v%b f%b want %h v1 f0", i, m_instr, fetch_valid, fetch_fault, w[i]); end
        end
        fetch_req = 1'b0;
        cyc();
    endtask

    task automatic test_overflow();
        logic [DW-1:0] w[$];
        for (int i = 0; i < DEP + 1; i++) w.push_back(DW'($urandom));
        do_load(w);
        n_cmp++; if (load_count !== 6'd16) begin n_err++; $display("FAIL ovf_count got %0d want 16", load_count); end
        n_cmp++; if (load_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", load_ovf); end
        for (int i = 0; i < DEP; i++) begin
            fetch_req = 1'b1;
            pc = AW'(i);
            cyc();
            n_cmp++; if (m_instr !== w[i]) begin n_err++; $display("FAIL ovf_mem addr %0d got %h want %h", i, m_instr, w[i]); end
        end
        fetch_req = 1'b0;
        cyc();
    endtask

    task automatic test_stall();
        fetch_req = 1'b1;
        pc = 5'd3;
        cyc();
        n_cmp++; if (m_instr !== ref_mem[3] || fetch_valid !== 1'b1) begin n_err++; $display("FAIL stall_first got %h v%b want %h v1", m_instr, fetch_valid, ref_mem[3]); end
        stall = 1'b1;
        pc = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready cycle %0d got %b want 0", i, fetch_ready); end
            cyc();
            n_cmp++; if (m_instr !== ref_mem[3] || fetch_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold cycle %0d got %h v%b want %h v1", i, m_instr, fetch_valid, ref_mem[3]); end
        end
        stall = 1'b0;
        fetch_req = 1'b0;
        cyc();
        n_cmp++; if (m_instr !== ref_mem[3] || fetch_valid !== 1'b0) begin n_err++; $display("FAIL stall_release got %h v%b want %h v0", m_instr, fetch_valid, ref_mem[3]); end
    endtask

    task automatic test_fault();
        int addrs[3] = '{20, 16, 15};
        for (int i = 0; i < 3; i++) begin
            logic [DW-1:0] exp_m;
            fetch_req = 1'b1;
            pc = AW'(addrs[i]);
            exp_m = (addrs[i] < DEP) ? ref_mem[addrs[i]] : '0;
            cyc();
            n_cmp++; if (m_instr !== exp_m || fetch_valid !== 1'b1 || fetch_fault !== (addrs[i] >= DEP))
                begin n_err++; $display("FAIL fault addr %0d got %h v%b f%b want %h v1 f%b", addrs[i], m_instr, fetch_valid, fetch_fault, exp_m, addrs[i] >= DEP); end
        end
        fetch_req = 1'b1;
        pc = 5'd20;
        cyc();
        fetch_req = 1'b0;
        cyc();
        n_cmp++; if (m_instr !== '0 || {fetch_valid, fetch_fault} !== 2'b00) begin n_err++; $display("FAIL fault_idle got %h v%b f%b want 0000 v0 f0", m_instr, fetch_valid, fetch_fault); end
    endtask

    task automatic test_start_done_same();
        load_start = 1'b1;
        load_done  = 1'b1;
        cyc();
        load_start = 1'b0;
        load_done  = 1'b0;
        #1;
        n_cmp++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL same_ready got %b want 0", fetch_ready); end
        load_wr_en = 1'b1;
        load_data  = 16'hBEEF;
        ref_mem[0] = 16'hBEEF;
        cyc();
        load_wr_en = 1'b0;
        n_cmp++; if (load_count !== 6'd1) begin n_err++; $display("FAIL same_count got %0d want 1", load_count); end
        load_done = 1'b1;
        cyc();
        load_done = 1'b0;
        fetch_req = 1'b1;
        pc = 5'd0;
        cyc();
        n_cmp++; if (m_instr !== 16'hBEEF || fetch_valid !== 1'b1) begin n_err++; $display("FAIL same_fetch got %h v%b want beef v1", m_instr, fetch_valid); end
        load_start = 1'b1;
        pc = 5'd1;
        cyc();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL leave_run_valid got %b want 0", fetch_valid); end
        load_done = 1'b1;
        cyc();
        load_done = 1'b0;
    endtask

    task automatic test_reset_midload();
        logic [DW-1:0] w0, w1;
        w0 = DW'($urandom);
        w1 = DW'($urandom);
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        load_wr_en = 1'b1;
        load_data = w0; ref_mem[0] = w0; cyc();
        load_data = w1; ref_mem[1] = w1; cyc();
        load_wr_en = 1'b0;
        n_cmp++; if (load_count !== 6'd2) begin n_err++; $display("FAIL midload_count got %0d want 2", load_count); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (load_count !== 6'd0) begin n_err++; $display("FAIL midload_reset_count got %0d want 0", load_count); end
        cyc();
        rst_n = 1'b1;
        cyc();
        n_cmp++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL midload_idle got %b want 0", fetch_ready); end
        load_done = 1'b1;
        cyc();
        load_done = 1'b0;
        fetch_req = 1'b1;
        pc = 5'd1;
        cyc();
        n_cmp++; if (m_instr !== w1 || fetch_valid !== 1'b1) begin n_err++; $display("FAIL midload_fetch got %h v%b want %h v1", m_instr, fetch_valid, w1); end
        fetch_req = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            logic [DW-1:0] w[$];
            int n;
            bit exp_v, exp_f, m_known;
            logic [DW-1:0] exp_m;
            n = $urandom_range(1, DEP);
            w = {};
            for (int i = 0; i < n; i++) w.push_back(DW'($urandom));
            do_load(w);
            n_cmp++; if (load_count !== (AW+1)'(n) || load_ovf !== 1'b0) begin n_err++; $display("FAIL rand_load round %0d got %0d o%b want %0d o0", round, load_count, load_ovf, n); end
            exp_v = 1'b0; exp_f = 1'b0; m_known = 1'b0; exp_m = '0;
            for (int c = 0; c < 60; c++) begin
                int a;
                a = $urandom_range(0, 23);
                fetch_req = ($urandom_range(0, 3) != 0);
                stall     = ($urandom_range(0, 3) == 0);
                pc        = AW'(a);
                #1;
                n_cmp++; if (fetch_ready !== !stall) begin n_err++; $display("FAIL rand_ready cycle %0d got %b want %b", c, fetch_ready, !stall); end
                if (fetch_req && !stall) begin
                    exp_v = 1'b1;
                    exp_f = (a >= DEP);
                    m_known = (a >= DEP) || ref_known[a];
                    exp_m = (a >= DEP) ? '0 : ref_mem[a];
                end else if (!stall) begin
                    exp_v = 1'b0;
                    exp_f = 1'b0;
                end
                cyc();
                n_cmp++; if (fetch_valid !== exp_v || fetch_fault !== exp_f || (m_known && m_instr !== exp_m))
                    begin n_err++; $display("FAIL rand_fetch round %0d cycle %0d got %h v%b f%b want %h v%b f%b", round, c, m_instr, fetch_valid, fetch_fault, exp_m, exp_v, exp_f); end
            end
            fetch_req = 1'b0;
            stall = 1'b0;
            cyc();
        end
    endtask

    initial begin
        for (int i = 0; i < DEP; i++) begin
            ref_mem[i] = '0;
            ref_known[i] = 1'b0;
        end
        test_reset();
        test_basic_fetch();
        test_overflow();
        test_stall();
        test_fault();
        test_start_done_same();
        test_reset_midload();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
